// File: rtl/matrix_reg_file.sv
// rtl/matrix_reg_file.sv - DEPTH x WIDTH matrix operand register file; optional read bypass via MATRIX_REG_FILE_BYPASS_EN
module matrix_reg_file #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 9,
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [WIDTH-1:0]       ld_data,
    output logic                   ld_ready,
    output logic [AW:0]            ld_count,
    output logic                   full,
    input  logic [AW-1:0]          rd_addr_a,
    input  logic [AW-1:0]          rd_addr_b,
    output logic [WIDTH-1:0]       rd_data_a,
    output logic [WIDTH-1:0]       rd_data_b,
    output logic [DEPTH*WIDTH-1:0] mat_out
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             st_acc;
    logic             rnd_acc;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;

    assign ld_ready = (state == S_LOAD);
    assign full     = (state == S_FULL);

    // Stream and random writes are mutually exclusive (LOAD vs. not LOAD), so one write port suffices.
    assign st_acc  = ld_ready & ld_valid & ~ld_start;
    assign rnd_acc = wr_en & ~ld_ready & ({1'b0, wr_addr} < DEPTH_W);
    assign we      = st_acc | rnd_acc;
    assign wa      = st_acc ? ld_count[AW-1:0] : wr_addr;
    assign wd      = st_acc ? ld_data : wr_data;

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        if ({1'b0, addr} >= DEPTH_W) return '0;
`ifdef MATRIX_REG_FILE_BYPASS_EN
        if (we && (addr == wa)) return wd;
`endif
        return mem[addr];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ld_count  <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rd_data_a <= read_port(rd_addr_a);
            rd_data_b <= read_port(rd_addr_b);
            if (we) mem[wa] <= wd;
            if (ld_start) begin
                state    <= S_LOAD;
                ld_count <= '0;
            end else if (st_acc) begin
                ld_count <= ld_count + 1'b1;
                if (ld_count == LAST) state <= S_FULL;
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_mat
        assign mat_out[k*WIDTH +: WIDTH] = mem[k];
    end
endmodule

// File: tb/tb_matrix_reg_file.sv
// tb/tb_matrix_reg_file.sv - scoreboard bench for matrix_reg_file against an array reference model
module tb_matrix_reg_file;
    localparam int WIDTH = 16;
    localparam int DEPTH = 9;
    localparam int AW    = 4;
    localparam int MW    = DEPTH * WIDTH;
`ifdef MATRIX_REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             wr_en, ld_start, ld_valid, ld_ready, full;
    logic [AW-1:0]    wr_addr, rd_addr_a, rd_addr_b;
    logic [WIDTH-1:0] wr_data, ld_data, rd_data_a, rd_data_b;
    logic [AW:0]      ld_count;
    logic [MW-1:0]    mat_out;

    always #5 clk = ~clk;

    matrix_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_count(ld_count), .full(full),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .mat_out(mat_out)
    );

    typedef struct {
        int               edge_no;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [AW:0]      cnt;
        logic             fl;
        logic             rdy;
        logic [MW-1:0]    mat;
    } exp_t;

    exp_t             q[$];
    int               edge_cnt = 0;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [WIDTH-1:0] m [DEPTH];
    int               m_cnt;
    bit               m_load, m_full;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        m_cnt  = 0;
        m_load = 1'b0;
        m_full = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rd_model(input int ra, input int widx, input logic [WIDTH-1:0] wval);
        if (ra >= DEPTH) return '0;
        if (BYP && widx == ra) return wval;
        return m[ra];
    endfunction

    // Drive one cycle, advance the model, queue what the DUT must show after the coming edge.
    task automatic step(input bit we, input int wa, input logic [WIDTH-1:0] wd, input bit st,
                        input bit lv, input logic [WIDTH-1:0] ld, input int ra, input int rb);
        exp_t             e;
        int               widx;
        logic [WIDTH-1:0] wval;
        widx = -1;
        wval = '0;
        wr_en = we; wr_addr = wa[AW-1:0]; wr_data = wd;
        ld_start = st; ld_valid = lv; ld_data = ld;
        rd_addr_a = ra[AW-1:0]; rd_addr_b = rb[AW-1:0];
        if (m_load && lv && !st) begin
            widx = m_cnt; wval = ld;
        end else if (we && !m_load && wa < DEPTH) begin
            widx = wa; wval = wd;
        end
        e.a = rd_model(ra, widx, wval);
        e.b = rd_model(rb, widx, wval);
        if (widx >= 0) m[widx] = wval;
        if (st) begin
            m_load = 1'b1; m_full = 1'b0; m_cnt = 0;
        end else if (widx >= 0 && m_load) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_load = 1'b0; m_full = 1'b1;
            end
        end
        e.edge_no = edge_cnt + 1;
        e.cnt     = m_cnt[AW:0];
        e.fl      = m_full;
        e.rdy     = m_load;
        for (int k = 0; k < DEPTH; k++) e.mat[k*WIDTH +: WIDTH] = m[k];
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                chk("rst_rd_a", MW'(rd_data_a), '0);
                chk("rst_rd_b", MW'(rd_data_b), '0);
                chk("rst_ld_count", MW'(ld_count), '0);
                chk("rst_full", MW'(full), '0);
                chk("rst_ld_ready", MW'(ld_ready), '0);
                chk("rst_mat_out", mat_out, '0);
            end else begin
                while (q.size() > 0 && q[0].edge_no <= edge_cnt) begin
                    e = q.pop_front();
                    chk("rd_data_a", MW'(rd_data_a), MW'(e.a));
                    chk("rd_data_b", MW'(rd_data_b), MW'(e.b));
                    chk("ld_count", MW'(ld_count), MW'(e.cnt));
                    chk("full", MW'(full), MW'(e.fl));
                    chk("ld_ready", MW'(ld_ready), MW'(e.rdy));
                    chk("mat_out", mat_out, e.mat);
                end
            end
        end
    end

    initial begin
        wr_en = 0; wr_addr = '0; wr_data = '0; ld_start = 0; ld_valid = 0; ld_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        mreset();
        #3 rst_n = 1'b0;
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full stream load of 0x0101..0x0909 with an ignored random write mid-load
        step(0, 0, '0, 1, 0, '0, 0, 0);
        for (int k = 0; k < DEPTH; k++)
            step(k == 4, 3, 16'hDEAD, 0, 1, WIDTH'(16'h0101 * (k + 1)), k, 8 - k);
        step(0, 0, '0, 0, 0, '0, 0, 8);
        step(0, 0, '0, 0, 0, '0, 15, 3);
        step(1, 3, 16'hBEEF, 0, 0, '0, 3, 0);
        step(1, 12, 16'h5555, 0, 0, '0, 3, 12);
        step(1, 5, 16'h1234, 0, 0, '0, 5, 5);
        step(0, 0, '0, 0, 0, '0, 5, 3);

        // Stalled stream, valid on the ld_start cycle must be ignored
        step(0, 0, '0, 1, 1, 16'h7777, 0, 0);
        for (int k = 0; k < 18; k++)
            step(0, 0, '0, 0, (k % 2) == 0, WIDTH'(16'h1000 + k), k % 9, (k + 4) % 9);

        // Restart mid-load
        step(0, 0, '0, 1, 0, '0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, '0, 0, 1, WIDTH'(16'h2000 + k), k, 0);
        step(0, 0, '0, 1, 1, 16'h3333, 0, 0);
        for (int k = 0; k < DEPTH; k++) step(0, 0, '0, 0, 1, WIDTH'(16'h4000 + k), k, 1);

        // Asynchronous reset in the middle of a load
        step(0, 0, '0, 1, 0, '0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, '0, 0, 1, WIDTH'(16'h5000 + k), k, 2);
        #6 rst_n = 1'b0;
        mreset();
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 1500; i++)
            step(($urandom % 3) == 0, int'($urandom % 16), WIDTH'($urandom),
                 ($urandom % 20) == 0, ($urandom % 3) != 0, WIDTH'($urandom),
                 int'($urandom % 16), int'($urandom % 16));

        repeat (3) @(negedge clk);
        #2;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
